player_ctrl_gen: RTL and testbench

Converts four raw, asynchronous direction buttons into the one-cycle `ctrl_up/down/left/right` move pulses consumed by the player position block. Each button is synchronised and debounced. A debounced press produces one move pulse, and an optional hold-to-repeat engine produces further pulses while the button stays down. The block sits between the board I/O pins and the player block, in the `clk` domain.

---
 rtl/player_pkg.sv | 12 +
 rtl/ctrl_debounce.sv | 28 ++
 rtl/player_ctrl_gen.sv | 83 ++++++++
 tb/tb_player_ctrl_gen.sv | 113 +++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// player_pkg: direction indices and pulse FSM state encoding shared by the player control block
package player_pkg;
  localparam int DIR_UP = 0;
  localparam int DIR_DOWN = 1;
  localparam int DIR_LEFT = 2;
  localparam int DIR_RIGHT = 3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
`ifdef PLAYER_CTRL_REPEAT_EN
  localparam logic [1:0] ST_REPEAT = 2'd2;
`endif
endpackage

// File: rtl/ctrl_debounce.sv
// ctrl_debounce: 2-flop synchroniser + debounce counter; ports clk, reset, btn (raw) -> level (debounced), level_nxt (level after this edge)
module ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic level_nxt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic sync1, sync2, done;
  logic [CW-1:0] cnt;
  assign done = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign level_nxt = done ? sync2 : level;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      level <= level_nxt;
      cnt <= (sync2 == level || done) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/player_ctrl_gen.sv
// player_ctrl_gen: debounced buttons -> one-cycle move pulses with axis-conflict masking; ports clk, reset, btn_* in, ctrl_* pulses and btn_state {right,left,down,up} out; hold-to-repeat enabled by PLAYER_CTRL_REPEAT_EN
module player_ctrl_gen
  import player_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       ctrl_up,
  output logic       ctrl_down,
  output logic       ctrl_left,
  output logic       ctrl_right,
  output logic [3:0] btn_state
);
  logic [3:0] btn_raw, lvl_nxt, pulse;
  logic ud, lr;
  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};
  assign ud = btn_state[DIR_UP] & btn_state[DIR_DOWN];
  assign lr = btn_state[DIR_LEFT] & btn_state[DIR_RIGHT];
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad
    $error("player_ctrl_gen: parameters must be >= 1");
  end
`ifdef PLAYER_CTRL_REPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
`endif
  for (genvar i = 0; i < 4; i++) begin : g_btn
    logic [1:0] state;
    ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk),
      .reset(reset),
      .btn(btn_raw[i]),
      .level(btn_state[i]),
      .level_nxt(lvl_nxt[i])
    );
`ifdef PLAYER_CTRL_REPEAT_EN
    logic [RW-1:0] cnt;
    logic expire;
    assign expire = (state != ST_IDLE) && (cnt == RW'(1));
    // lvl_nxt gating suppresses a repeat landing on the edge where the level falls
    assign pulse[i] = lvl_nxt[i] && ((state == ST_IDLE && btn_state[i]) || expire);
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        state <= ST_IDLE;
        cnt <= '0;
      end else if (!btn_state[i]) begin
        state <= ST_IDLE;
        cnt <= '0;
      end else if (state == ST_IDLE) begin
        state <= ST_DELAY;
        cnt <= RW'(REPEAT_DELAY);
      end else if (expire) begin
        state <= ST_REPEAT;
        cnt <= RW'(REPEAT_PERIOD);
      end else
        cnt <= cnt - 1'b1;
`else
    assign pulse[i] = lvl_nxt[i] && btn_state[i] && (state == ST_IDLE);
    always_ff @(posedge clk or posedge reset)
      if (reset)
        state <= ST_IDLE;
      else
        state <= btn_state[i] ? ST_DELAY : ST_IDLE;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ctrl_up <= 1'b0;
      ctrl_down <= 1'b0;
      ctrl_left <= 1'b0;
      ctrl_right <= 1'b0;
    end else begin
      ctrl_up <= pulse[DIR_UP] & ~ud;
      ctrl_down <= pulse[DIR_DOWN] & ~ud;
      ctrl_left <= pulse[DIR_LEFT] & ~lr;
      ctrl_right <= pulse[DIR_RIGHT] & ~lr;
    end
endmodule

// File: tb/tb_player_ctrl_gen.sv
// tb_player_ctrl_gen: directed self-checking bench for player_ctrl_gen with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3
module tb_player_ctrl_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic ctrl_up, ctrl_down, ctrl_left, ctrl_right;
  logic [3:0] btn_state, ctrl;
  int errors = 0;
  int checks = 0;
`ifdef PLAYER_CTRL_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif
  player_ctrl_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) dut (
    .clk(clk),
    .reset(reset),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .ctrl_up(ctrl_up),
    .ctrl_down(ctrl_down),
    .ctrl_left(ctrl_left),
    .ctrl_right(ctrl_right),
    .btn_state(btn_state)
  );
  assign ctrl = {ctrl_right, ctrl_left, ctrl_down, ctrl_up};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int k, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask
  function automatic logic rep(input int k, input int fall);
    return REP && k >= 15 && k < fall && (k - 15) % 3 == 0;
  endfunction
  task automatic rst_cycle();
    reset = 1'b1;
    {btn_right, btn_left, btn_down, btn_up} = 4'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    logic pat [5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    chk("reset_ctrl", 0, ctrl, 4'b0);
    chk("reset_state", 0, btn_state, 4'b0);
    rst_cycle();
    btn_up = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk("hold_ctrl", k, ctrl, {3'b0, k == 7 || rep(k, 36)});
      chk("hold_state", k, btn_state, {3'b0, k >= 6 && k < 36});
      if (k == 30) btn_up = 1'b0;
    end
    rst_cycle();
    btn_left = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) btn_left = 1'b0;
      chk("glitch_ctrl", k, ctrl, 4'b0);
      chk("glitch_state", k, btn_state, 4'b0);
    end
    rst_cycle();
    {btn_right, btn_down, btn_up} = 3'b111;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      chk("conflict_ctrl", k, ctrl, {k == 7 || rep(k, 18), 3'b0});
      chk("conflict_state", k, btn_state, (k >= 6 && k < 18) ? 4'b1011 : 4'b0000);
      if (k == 12) {btn_right, btn_down, btn_up} = 3'b000;
    end
    rst_cycle();
    btn_down = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 7) chk("pre_reset_pulse", k, ctrl, 4'b0010);
    end
    reset = 1'b1;
    #1;
    chk("in_reset_ctrl", 0, ctrl, 4'b0);
    chk("in_reset_state", 0, btn_state, 4'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("in_reset_ctrl", k, ctrl, 4'b0);
      chk("in_reset_state", k, btn_state, 4'b0);
    end
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("post_reset_ctrl", k, ctrl, (k == 7) ? 4'b0010 : 4'b0000);
      chk("post_reset_state", k, btn_state, (k >= 6) ? 4'b0010 : 4'b0000);
    end
    rst_cycle();
    for (int j = 0; j < 5; j++) begin
      btn_right = pat[j];
      @(negedge clk);
      chk("bounce_ctrl", j, ctrl, 4'b0);
      chk("bounce_state", j, btn_state, 4'b0);
    end
    btn_right = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("steady_ctrl", k, ctrl, (k == 7) ? 4'b1000 : 4'b0000);
      chk("steady_state", k, btn_state, (k >= 6) ? 4'b1000 : 4'b0000);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
